// File: rtl/duty_ramp_pkg.sv
// Shared types and helpers for the duty_ramp motor command stage.
package duty_ramp_pkg;

  typedef enum logic [1:0] {
    RUN,
    DECEL,
    DEAD,
    HALT
  } ramp_state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Wide enough for any sign-extended command; callers narrow the result.
  localparam int unsigned MAG_W = 32;

  function automatic logic [MAG_W-1:0] sat_mag(input logic [MAG_W-1:0] cmd,
                                               input logic [MAG_W-1:0] limit);
    logic [MAG_W-1:0] mag;
    mag = cmd[MAG_W-1] ? (~cmd + MAG_W'(1)) : cmd;
    return (mag > limit) ? limit : mag;
  endfunction

endpackage

// File: rtl/ramp_tick.sv
// Free-running prescaler: one-cycle tick every RAMP_DIV clocks.
module ramp_tick #(
  parameter int unsigned RAMP_DIV = 125000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// Slew-limited duty/direction/brake command stage ahead of pwm.
// Optional DUTY_RAMP_CLAMP_EN adds a live duty_max clamp on the target.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int unsigned R          = 16,
  parameter int unsigned STEP       = 256,
  parameter int unsigned RAMP_DIV   = 125000,
  parameter int unsigned DEAD_TICKS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [R+1:0] cmd,
  input  logic         cmd_valid,
`ifdef DUTY_RAMP_CLAMP_EN
  input  logic [R:0]   duty_max,
`endif
  output logic [R:0]   duty,
  output logic         dir,
  output logic         brake,
  output logic         at_target
);

  localparam int unsigned DW    = R + 2;
  localparam int unsigned CNT_W = $clog2(DEAD_TICKS + 1);

  localparam logic [DW-1:0]    FULL     = {2'b01, {R{1'b0}}};
  localparam logic [DW-1:0]    STEP_W   = DW'(STEP);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_TICKS - 1);

  ramp_state_t      state, state_n;
  logic [R:0]       duty_n, tgt_mag, tgt_mag_n, eff_mag, eff_mag_n;
  logic             dir_n, brake_n, at_target_n, tgt_dir, tgt_dir_n;
  logic [CNT_W-1:0] dead_cnt, dead_n;
  logic [MAG_W-1:0] cmd_ext;
  logic             tick;

  ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // One STEP toward tgt without overshoot; R+2 bits so nothing wraps.
  function automatic logic [R:0] step_toward(input logic [R:0] cur,
                                             input logic [R:0] tgt);
    logic [DW-1:0] c, t, up, dn, r;
    c  = DW'(cur);
    t  = DW'(tgt);
    up = c + STEP_W;
    dn = (c > STEP_W) ? (c - STEP_W) : '0;
    if (c < t) begin
      r = (up > t) ? t : up;
    end else if (c > t) begin
      r = (dn < t) ? t : dn;
    end else begin
      r = c;
    end
    return (R+1)'(r);
  endfunction

  always_comb begin
    cmd_ext   = {{(MAG_W-DW){cmd[R+1]}}, cmd};
    tgt_mag_n = tgt_mag;
    tgt_dir_n = tgt_dir;
    if (cmd_valid) begin
      tgt_mag_n = (R+1)'(sat_mag(cmd_ext, MAG_W'(FULL)));
      if (cmd != '0) begin
        tgt_dir_n = cmd[R+1] ? DIR_REV : DIR_FWD;
      end
    end
  end

  // The clamp acts on the stored target each cycle, so a lowered duty_max
  // is reached through the normal slew path rather than a jump.
  always_comb begin
`ifdef DUTY_RAMP_CLAMP_EN
    eff_mag   = (R+1)'(sat_mag(MAG_W'(tgt_mag), MAG_W'(duty_max)));
    eff_mag_n = (R+1)'(sat_mag(MAG_W'(tgt_mag_n), MAG_W'(duty_max)));
`else
    eff_mag   = tgt_mag;
    eff_mag_n = tgt_mag_n;
`endif
  end

  always_comb begin
    state_n = state;
    duty_n  = duty;
    dir_n   = dir;
    brake_n = brake;
    dead_n  = dead_cnt;
    if (!enable) begin
      state_n = HALT;
      duty_n  = '0;
      brake_n = 1'b1;
      dead_n  = '0;
    end else begin
      unique case (state)
        HALT: begin
          state_n = RUN;
          brake_n = 1'b0;
          dir_n   = tgt_dir;
        end
        RUN, DECEL: begin
          if (tick) begin
            if (tgt_dir == dir) begin
              state_n = RUN;
              duty_n  = step_toward(duty, eff_mag);
            end else begin
              state_n = DECEL;
              duty_n  = step_toward(duty, '0);
              if (duty_n == '0) begin
                state_n = DEAD;
                brake_n = 1'b1;
                dead_n  = '0;
              end
            end
          end
        end
        DEAD: begin
          if (tick) begin
            if (dead_cnt == DEAD_END) begin
              state_n = RUN;
              brake_n = 1'b0;
              dir_n   = tgt_dir;
              dead_n  = '0;
            end else begin
              dead_n = dead_cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = RUN;
      endcase
    end
    // Built from next-cycle values so the flag lines up with registered duty.
    at_target_n = (state_n == RUN) && (duty_n == eff_mag_n) &&
                  (dir_n == tgt_dir_n) && enable;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      duty      <= '0;
      dir       <= DIR_FWD;
      brake     <= 1'b0;
      at_target <= 1'b1;
      tgt_mag   <= '0;
      tgt_dir   <= DIR_FWD;
      dead_cnt  <= '0;
    end else begin
      state     <= state_n;
      duty      <= duty_n;
      dir       <= dir_n;
      brake     <= brake_n;
      at_target <= at_target_n;
      tgt_mag   <= tgt_mag_n;
      tgt_dir   <= tgt_dir_n;
      dead_cnt  <= dead_n;
    end
  end

endmodule
